// File: rtl/video_mode_detect_pkg.sv
// Shared definitions for the Dreamcast video mode detector.
// Holds the mode encoding, the timing windows used to recognise 31 kHz and
// 15 kHz line rates and field heights, the interlace phase threshold, the
// lock FSM state encoding and a small absolute-difference helper.
package video_mode_detect_pkg;

  // Mode encoding, also used as the classification result (UNKNOWN = invalid).
  localparam logic [1:0] MODE_UNKNOWN = 2'd0;
  localparam logic [1:0] MODE_480P    = 2'd1;
  localparam logic [1:0] MODE_480I    = 2'd2;
  localparam logic [1:0] MODE_240P    = 2'd3;

  // Line length windows in 54 MHz clocks.
  localparam logic [11:0] LINE31_MIN = 12'd1700;
  localparam logic [11:0] LINE31_MAX = 12'd1732;
  localparam logic [11:0] LINE15_MIN = 12'd3400;
  localparam logic [11:0] LINE15_MAX = 12'd3464;

  // Lines-per-field windows.
  localparam logic [9:0] FIELD480P_MIN = 10'd520;
  localparam logic [9:0] FIELD480P_MAX = 10'd530;
  localparam logic [9:0] FIELD15K_MIN  = 10'd258;
  localparam logic [9:0] FIELD15K_MAX  = 10'd268;

  // Minimum vsync phase shift between fields that marks interlaced video.
  localparam logic [11:0] INTERLACE_PHASE_MIN = 12'd800;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lockState_t;

  function automatic logic [11:0] absDiff12(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/video_mode_detect_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low sync line, followed
// by a registered falling-edge pulse.
// Ports:
//   clock    - sampling clock
//   reset    - synchronous active-high reset (line assumed idle high)
//   syncN_i  - raw asynchronous active-low sync input
//   fall_o   - one-cycle pulse, third clock after the input falls
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic syncN_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic syncPrev_q;
  logic fall_q;

  // Synchronizer chain plus one history flop. The pulse is registered so the
  // downstream counters see a clean, glitch-free single-cycle strobe.
  // Everything resets to the idle-high level so reset release never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q     <= 1'b1;
      sync_q     <= 1'b1;
      syncPrev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      meta_q     <= syncN_i;
      sync_q     <= meta_q;
      syncPrev_q <= sync_q;
      fall_q     <= syncPrev_q & ~sync_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/video_mode_detect.sv
// Measures raw Dreamcast hsync/vsync timing and classifies the video as
// 480p, 480i or 240p, committing a mode only after several consecutive
// identical field classifications.
// Ports:
//   clock, reset  - 54 MHz clock, synchronous active-high reset
//   _hsync,_vsync - raw active-low asynchronous sync inputs
//   mode          - committed mode (0 unknown, 1 480p, 2 480i, 3 240p)
//   locked        - a mode is committed and sync is present
//   line_doubler  - mode is 480i or 240p
//   add_line      - mode is 240p
//   field         - 480i field parity, 0 otherwise
//   mode_change   - one-cycle pulse whenever mode changes
//   line_length   - last hsync-to-hsync period in clocks
//   field_lines   - last lines-per-field count
module video_mode_detect
  import video_mode_detect_pkg::*;
#(
  parameter logic [3:0]  STABLE_FIELDS = 4'd3,
  parameter logic [11:0] HSYNC_TIMEOUT = 12'd4095,
  parameter logic [11:0] LINE31_LO     = LINE31_MIN,
  parameter logic [11:0] LINE31_HI     = LINE31_MAX,
  parameter logic [11:0] LINE15_LO     = LINE15_MIN,
  parameter logic [11:0] LINE15_HI     = LINE15_MAX,
  parameter logic [9:0]  FIELD480P_LO  = FIELD480P_MIN,
  parameter logic [9:0]  FIELD480P_HI  = FIELD480P_MAX,
  parameter logic [9:0]  FIELD15K_LO   = FIELD15K_MIN,
  parameter logic [9:0]  FIELD15K_HI   = FIELD15K_MAX,
  parameter logic [11:0] PHASE_THRESH  = INTERLACE_PHASE_MIN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        _hsync,
  input  logic        _vsync,
  output logic [1:0]  mode,
  output logic        locked,
  output logic        line_doubler,
  output logic        add_line,
  output logic        field,
  output logic        mode_change,
  output logic [11:0] line_length,
  output logic [9:0]  field_lines
);

  logic hsEdge;
  logic vsEdge;

  sync_edge uHsyncEdge (
    .clock   (clock),
    .reset   (reset),
    .syncN_i (_hsync),
    .fall_o  (hsEdge)
  );

  sync_edge uVsyncEdge (
    .clock   (clock),
    .reset   (reset),
    .syncN_i (_vsync),
    .fall_o  (vsEdge)
  );

  logic [11:0] lineCount_q, lineCount_d, lineCountInc;
  logic [11:0] lineLength_q, lineLength_d;
  logic [9:0]  fieldCount_q, fieldCount_d, fieldCountInc, fieldAfterHs;
  logic [9:0]  fieldLines_q, fieldLines_d;
  logic [11:0] phase_q, phase_d, curPhase;

  // Line and field measurement. When hsync and vsync edges land in the same
  // cycle the hsync is handled first: the line that just ended is counted
  // into the field being closed, and the vsync phase is taken as zero.
  always_comb begin
    lineCountInc  = (lineCount_q == 12'hFFF) ? lineCount_q : lineCount_q + 12'd1;
    fieldCountInc = (fieldCount_q == 10'h3FF) ? fieldCount_q : fieldCount_q + 10'd1;
    lineCount_d   = lineCountInc;
    lineLength_d  = lineLength_q;
    curPhase      = lineCount_q;
    fieldAfterHs  = fieldCount_q;
    if (hsEdge) begin
      lineLength_d = lineCountInc;
      lineCount_d  = '0;
      curPhase     = '0;
      fieldAfterHs = fieldCountInc;
    end
    fieldCount_d = fieldAfterHs;
    fieldLines_d = fieldLines_q;
    phase_d      = phase_q;
    if (vsEdge) begin
      fieldLines_d = fieldAfterHs;
      fieldCount_d = '0;
      phase_d      = curPhase;
    end
  end

  logic        lineIs31, lineIs15, fieldIs480p, fieldIs15k;
  logic [11:0] phaseDiff;
  logic [1:0]  classNow;

  // Field classification from the freshly updated measurements. Interlace is
  // recognised by the vsync landing at a clearly different point within the
  // line compared with the previous field.
  always_comb begin
    lineIs31    = (lineLength_d >= LINE31_LO) && (lineLength_d <= LINE31_HI);
    lineIs15    = (lineLength_d >= LINE15_LO) && (lineLength_d <= LINE15_HI);
    fieldIs480p = (fieldLines_d >= FIELD480P_LO) && (fieldLines_d <= FIELD480P_HI);
    fieldIs15k  = (fieldLines_d >= FIELD15K_LO) && (fieldLines_d <= FIELD15K_HI);
    phaseDiff   = absDiff12(curPhase, phase_q);
    classNow    = MODE_UNKNOWN;
    if (lineIs31 && fieldIs480p) begin
      classNow = MODE_480P;
    end else if (lineIs15 && fieldIs15k) begin
      classNow = (phaseDiff >= PHASE_THRESH) ? MODE_480I : MODE_240P;
    end
  end

  logic [1:0] fieldClass_q;
  logic       fieldClassValid_q;

  // Measurement registers plus the classification register, which is loaded
  // on every vsync edge and strobes the lock FSM one clock later.
  always_ff @(posedge clock) begin
    if (reset) begin
      lineCount_q       <= '0;
      lineLength_q      <= '0;
      fieldCount_q      <= '0;
      fieldLines_q      <= '0;
      phase_q           <= '0;
      fieldClass_q      <= MODE_UNKNOWN;
      fieldClassValid_q <= 1'b0;
    end else begin
      lineCount_q       <= lineCount_d;
      lineLength_q      <= lineLength_d;
      fieldCount_q      <= fieldCount_d;
      fieldLines_q      <= fieldLines_d;
      phase_q           <= phase_d;
      fieldClass_q      <= classNow;
      fieldClassValid_q <= vsEdge;
    end
  end

  lockState_t state_q;
  logic [1:0] cand_q;
  logic [3:0] matchCount_q;
  logic [1:0] mode_q;
  logic       locked_q;
  logic       lineDoubler_q;
  logic       addLine_q;
  logic       modeChange_q;

  // Lock FSM with registered outputs. A committed mode survives glitch fields
  // and invalid fields; only a fresh commit or an hsync timeout changes it.
  // Dropping to UNLOCKED on an invalid field just restarts acquisition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      cand_q        <= MODE_UNKNOWN;
      matchCount_q  <= '0;
      mode_q        <= MODE_UNKNOWN;
      locked_q      <= 1'b0;
      lineDoubler_q <= 1'b0;
      addLine_q     <= 1'b0;
      modeChange_q  <= 1'b0;
    end else begin
      modeChange_q <= 1'b0;
      if (lineCount_q >= HSYNC_TIMEOUT) begin
        state_q       <= ST_UNLOCKED;
        cand_q        <= MODE_UNKNOWN;
        matchCount_q  <= '0;
        mode_q        <= MODE_UNKNOWN;
        locked_q      <= 1'b0;
        lineDoubler_q <= 1'b0;
        addLine_q     <= 1'b0;
        modeChange_q  <= (mode_q != MODE_UNKNOWN);
      end else if (fieldClassValid_q) begin
        case (state_q)
          ST_UNLOCKED: begin
            if (fieldClass_q != MODE_UNKNOWN) begin
              cand_q       <= fieldClass_q;
              matchCount_q <= 4'd1;
              state_q      <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (fieldClass_q == MODE_UNKNOWN) begin
              state_q      <= ST_UNLOCKED;
              matchCount_q <= '0;
            end else if (fieldClass_q == cand_q) begin
              if (matchCount_q + 4'd1 >= STABLE_FIELDS) begin
                mode_q        <= cand_q;
                locked_q      <= 1'b1;
                lineDoubler_q <= cand_q[1];
                addLine_q     <= (cand_q == MODE_240P);
                modeChange_q  <= (cand_q != mode_q);
                matchCount_q  <= '0;
                state_q       <= ST_LOCKED;
              end else begin
                matchCount_q <= matchCount_q + 4'd1;
              end
            end else begin
              cand_q       <= fieldClass_q;
              matchCount_q <= 4'd1;
            end
          end
          ST_LOCKED: begin
            if (fieldClass_q == MODE_UNKNOWN) begin
              state_q <= ST_UNLOCKED;
            end else if (fieldClass_q != mode_q) begin
              cand_q       <= fieldClass_q;
              matchCount_q <= 4'd1;
              state_q      <= ST_ACQUIRE;
            end
          end
          default: state_q <= ST_UNLOCKED;
        endcase
      end
    end
  end

  logic field_q;

  // Field parity flips on each vsync while the committed mode is 480i and is
  // held at zero in every other mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      field_q <= 1'b0;
    end else if (mode_q != MODE_480I) begin
      field_q <= 1'b0;
    end else if (vsEdge) begin
      field_q <= ~field_q;
    end
  end

  assign mode         = mode_q;
  assign locked       = locked_q;
  assign line_doubler = lineDoubler_q;
  assign add_line     = addLine_q;
  assign field        = field_q;
  assign mode_change  = modeChange_q;
  assign line_length  = lineLength_q;
  assign field_lines  = fieldLines_q;

endmodule

// File: doc/video_mode_detect.md
# video_mode_detect

Measures the raw Dreamcast sync stream in the 54 MHz input domain and classifies the incoming video as 480p, 480i or 240p. It sits directly upstream of the input capture stage and drives its `line_doubler` and `add_line` controls from measured timing instead of static strap pins. Changes to the classified mode are debounced across fields so that a glitch on the sync lines cannot flip downstream configuration.

## Interface
Parameters:
- `STABLE_FIELDS`, 3: consecutive identical classifications required before the mode is committed.
- `HSYNC_TIMEOUT`, 4095: clocks without an hsync falling edge before the block declares loss of lock.

Ports:
- `clock`  in  1  54 MHz input clock.
- `reset`  in  1  synchronous, active-high.
- `_hsync`  in  1  raw DC hsync, active low, asynchronous.
- `_vsync`  in  1  raw DC vsync, active low, asynchronous.
- `mode`  out  2  committed mode: 0 unknown, 1 480p, 2 480i, 3 240p.
- `locked`  out  1  high while `mode` is committed and sync is present.
- `line_doubler`  out  1  high when `mode` is 2 or 3.
- `add_line`  out  1  high when `mode` is 3.
- `field`  out  1  field parity in 480i, toggled on each vsync; 0 in the other modes.
- `mode_change`  out  1  one-cycle pulse when `mode` changes value.
- `line_length`  out  12  last measured hsync-to-hsync period, in clocks.
- `field_lines`  out  10  last measured lines per field.

## Operation
- Both sync inputs pass through a 2-flop synchronizer, then a falling-edge detector.
- **Line counter (12 bit).** Counts clocks between hsync edges and saturates at 4095. On each hsync edge it latches into `line_length` and clears.
- **Line classification.**
  - 1700..1732 is a 31 kHz line.
  - 3400..3464 is a 15 kHz line.
  - Any other value is invalid.
- **Lines per field (10 bit).** Increments on each hsync edge and saturates at 1023. On a vsync edge it latches into `field_lines` and clears.
- **Vsync phase.** At a vsync edge, the current clock count is stored as the vsync phase. The previous field's phase is kept.
- **Field classification, made at every vsync edge:**
  - 31 kHz lines and `field_lines` 520..530 → 480p.
  - 15 kHz lines, `field_lines` 258..268, and |phase − previous phase| ≥ 800 → 480i.
  - 15 kHz lines, `field_lines` 258..268, and the phase difference < 800 → 240p.
  - Anything else → invalid.
- **FSM states: UNLOCKED, ACQUIRE, LOCKED.**
  - UNLOCKED: a valid classification loads a candidate, sets the match count to 1 and moves to ACQUIRE.
  - ACQUIRE, same candidate: the count increments. When it reaches `STABLE_FIELDS`, the FSM commits `mode`, moves to LOCKED and pulses `mode_change` if the value differs.
  - ACQUIRE, different valid class: reload the candidate with count 1.
  - ACQUIRE, invalid class: go to UNLOCKED.
  - LOCKED, same class: stay.
  - LOCKED, a different or invalid class: move to ACQUIRE with that candidate (count 1, or UNLOCKED if invalid). `mode` and `locked` hold their values until a new commit or an unlock.
- **Timeout.** When the line counter reaches `HSYNC_TIMEOUT` in any state:
  - go to UNLOCKED with `mode`=0 and `locked`=0;
  - pulse `mode_change` if `mode` was nonzero.
- **Simultaneous hsync and vsync edges in the same cycle.** Process the hsync edge first. The line just ended counts toward `field_lines`.

## Timing
- **Reset values.** `mode`=0, `locked`=0, `line_doubler`=0, `add_line`=0, `field`=0, `mode_change`=0, `line_length`=0, `field_lines`=0, FSM=UNLOCKED, all counters 0.
- **Reset mid-operation** discards any candidate and forces all outputs to these values on the next clock.
- **Sync input to edge detect:** 3 clocks.
- **Vsync edge detect to outputs:**
  - 1 clock to the classification register;
  - 1 further clock to updated `mode`, `locked`, `line_doubler`, `add_line` and the `mode_change` pulse.
- `line_doubler`, `add_line` and `locked` are registered and change only on the same clock as `mode`.
- `field` toggles 1 clock after the vsync edge detect, only while `mode`=2.

## Structure
- **Shared package.**
  - Mode encoding constants (MODE_UNKNOWN/480P/480I/240P).
  - Line-length and lines-per-field tolerance bounds.
  - The interlace phase threshold of 800.
  - The FSM state enumeration.
- **Sub-module `sync_edge`.** A 2-flop synchronizer plus registered falling-edge pulse, instantiated once for hsync and once for vsync.

## Test plan
- **480p.** Hsync period 1716, 525 lines, constant vsync phase → `mode`=1, `locked`=1 and `line_doubler`=0 two clocks after the 3rd vsync detect; `mode_change` pulses once.
- **240p.** Hsync period 3432, 263 lines, constant phase → `mode`=3, `line_doubler`=1, `add_line`=1 after 3 fields; `field` stays 0.
- **480i.** Hsync period 3432, 262/263 lines, vsync phase alternating 0/1716 → `mode`=2; `field` toggles every field.
- **Glitch, then switch.** Lock on 480p, inject one 240p field, then resume 480p → `mode` stays 1 with no `mode_change`. Then feed 3 × 240p fields → `mode`=3 with one `mode_change` pulse.
- **Hsync loss.** Stop hsync while locked → after 4095 clocks `mode`=0, `locked`=0 and `mode_change` pulses. Hsync period 2000 → never locks.
- **Reset.** Assert `reset` mid-ACQUIRE (after 2 matching fields) → all outputs reset next clock, and 3 fresh fields are needed to lock.
